seg_memory_map: RTL

Parametrised MMIO register file and run controller for multi-segment DMA AFUs. It sits between the mmio_if user port and the DMA datapath. It exposes NUM_SEGS segment write addresses and sizes, a go/done handshake with a run state machine, sticky status flags, a run cycle counter and a datapath readback value. It supersedes fixed four-segment memory maps.

---
 rtl/seg_memory_map_pkg.sv | 60 ++++++
 rtl/seg_memory_map_if.sv | 23 ++
 rtl/seg_memory_map_decode.sv | 49 ++++
 rtl/seg_memory_map.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg_memory_map_pkg.sv
// Shared types and constants for the multi-segment DMA MMIO register file.
package seg_mmap_pkg;

    // Run controller states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMPLETE
    } state_t;

    // What an MMIO address resolves to after decode
    typedef enum logic [2:0] {
        RK_NONE,
        RK_CTRL,
        RK_STATUS,
        RK_CYCLES,
        RK_CV,
        RK_SEG_ADDR,
        RK_SEG_SIZE
    } reg_kind_t;

    localparam int unsigned MMIO_DATA_WIDTH = 64;

    // Register offsets relative to the block base address
    localparam int unsigned CTRL_OFS   = 0;
    localparam int unsigned STATUS_OFS = 2;
    localparam int unsigned CYCLES_OFS = 4;
    localparam int unsigned CV_OFS     = 6;
    localparam int unsigned SEG_OFS    = 8;

    // CTRL bit positions
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    // STATUS bit positions
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;
    localparam int unsigned STATUS_ERR_BIT  = 2;
    localparam int unsigned STATUS_NSEG_LSB = 8;

    // Segment index width, enough for up to 16 segments
    localparam int unsigned SEG_IDX_W = 4;

    // Assemble the STATUS word from its fields
    function automatic logic [MMIO_DATA_WIDTH-1:0] pack_status(
        input logic       busy,
        input logic       doneSticky,
        input logic       errSticky,
        input logic [7:0] numSegs
    );
        logic [MMIO_DATA_WIDTH-1:0] s;
        s                       = '0;
        s[STATUS_BUSY_BIT]      = busy;
        s[STATUS_DONE_BIT]      = doneSticky;
        s[STATUS_ERR_BIT]       = errSticky;
        s[STATUS_NSEG_LSB +: 8] = numSegs;
        return s;
    endfunction

endpackage

// File: rtl/seg_memory_map_if.sv
// MMIO port bundle: a host drives reads/writes, the register file (user) answers.
interface mmio_if #(
    parameter int unsigned ADDR_W = 16
) ();

    logic                                      rd_en;
    logic [ADDR_W-1:0]                         rd_addr;
    logic [seg_mmap_pkg::MMIO_DATA_WIDTH-1:0]  rd_data;
    logic                                      wr_en;
    logic [ADDR_W-1:0]                         wr_addr;
    logic [seg_mmap_pkg::MMIO_DATA_WIDTH-1:0]  wr_data;

    modport host (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport user (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );

endinterface

// File: rtl/seg_memory_map_decode.sv
// Combinational MMIO address decode into a register kind and segment index.
// One instance serves the read port and another the write port.
module seg_mmap_decode
    import seg_mmap_pkg::*;
#(
    parameter int unsigned              NUM_SEGS        = 4,
    parameter int unsigned              MMIO_ADDR_WIDTH = 16,
    parameter logic [MMIO_ADDR_WIDTH-1:0] BASE_ADDR     = 16'h0050
) (
    input  logic [MMIO_ADDR_WIDTH-1:0] addr_i,
    output reg_kind_t                  kind_o,
    output logic [SEG_IDX_W-1:0]       idx_o
);

    localparam int unsigned SEG_WORD  = SEG_OFS / 2;
    localparam int unsigned SIZE_WORD = SEG_WORD + NUM_SEGS;
    localparam int unsigned END_WORD  = SEG_WORD + 2 * NUM_SEGS;

    logic [MMIO_ADDR_WIDTH-1:0] ofs;
    logic [MMIO_ADDR_WIDTH-1:0] word;

    // Registers are 64-bit words on even addresses; odd or out-of-window addresses decode to nothing
    always_comb begin
        kind_o = RK_NONE;
        idx_o  = '0;
        ofs    = addr_i - BASE_ADDR;
        word   = {1'b0, ofs[MMIO_ADDR_WIDTH-1:1]};
        if ((addr_i >= BASE_ADDR) && !ofs[0]) begin
            if (word == MMIO_ADDR_WIDTH'(CTRL_OFS / 2)) begin
                kind_o = RK_CTRL;
            end else if (word == MMIO_ADDR_WIDTH'(STATUS_OFS / 2)) begin
                kind_o = RK_STATUS;
            end else if (word == MMIO_ADDR_WIDTH'(CYCLES_OFS / 2)) begin
                kind_o = RK_CYCLES;
            end else if (word == MMIO_ADDR_WIDTH'(CV_OFS / 2)) begin
                kind_o = RK_CV;
            end else if ((word >= MMIO_ADDR_WIDTH'(SEG_WORD)) &&
                         (word <  MMIO_ADDR_WIDTH'(SIZE_WORD))) begin
                kind_o = RK_SEG_ADDR;
                idx_o  = SEG_IDX_W'(word - MMIO_ADDR_WIDTH'(SEG_WORD));
            end else if ((word >= MMIO_ADDR_WIDTH'(SIZE_WORD)) &&
                         (word <  MMIO_ADDR_WIDTH'(END_WORD))) begin
                kind_o = RK_SEG_SIZE;
                idx_o  = SEG_IDX_W'(word - MMIO_ADDR_WIDTH'(SIZE_WORD));
            end
        end
    end

endmodule

// File: rtl/seg_memory_map.sv
// MMIO register file and run controller for a multi-segment DMA AFU.
// Holds per-segment addresses/sizes, issues a go pulse, tracks the run with
// a cycle counter and sticky done/error flags, and exposes the datapath result.
module seg_memory_map
    import seg_mmap_pkg::*;
#(
    parameter int unsigned                ADDR_WIDTH      = 64,
    parameter int unsigned                NUM_SEGS        = 4,
    parameter int unsigned                SIZE_WIDTH      = 32,
    parameter int unsigned                MMIO_ADDR_WIDTH = 16,
    parameter logic [MMIO_ADDR_WIDTH-1:0] BASE_ADDR       = 16'h0050
) (
    input  logic                                clk,
    input  logic                                rst,
    mmio_if.user                                mmio,
    output logic [NUM_SEGS-1:0][ADDR_WIDTH-1:0] seg_addr,
    output logic [NUM_SEGS-1:0][SIZE_WIDTH-1:0] seg_size,
    output logic                                go,
    output logic                                busy,
    input  logic                                done,
    input  logic [ADDR_WIDTH-1:0]               cv_value
);

    state_t                               state_q, state_d;
    logic [MMIO_DATA_WIDTH-1:0]           cycles_q, cycles_d;
    logic                                 doneSticky_q, doneSticky_d;
    logic                                 errSticky_q, errSticky_d;
    logic                                 go_q, go_d;
    logic [NUM_SEGS-1:0][ADDR_WIDTH-1:0]  segAddr_q, segAddr_d;
    logic [NUM_SEGS-1:0][SIZE_WIDTH-1:0]  segSize_q, segSize_d;
    logic [MMIO_DATA_WIDTH-1:0]           rdData_q, rdData_d;

    reg_kind_t              rdKind, wrKind;
    logic [SEG_IDX_W-1:0]   rdIdx, wrIdx;
    logic                   startWr, clearWr, segWr;

    seg_mmap_decode #(
        .NUM_SEGS        (NUM_SEGS),
        .MMIO_ADDR_WIDTH (MMIO_ADDR_WIDTH),
        .BASE_ADDR       (BASE_ADDR)
    ) u_rd_decode (
        .addr_i (mmio.rd_addr),
        .kind_o (rdKind),
        .idx_o  (rdIdx)
    );

    seg_mmap_decode #(
        .NUM_SEGS        (NUM_SEGS),
        .MMIO_ADDR_WIDTH (MMIO_ADDR_WIDTH),
        .BASE_ADDR       (BASE_ADDR)
    ) u_wr_decode (
        .addr_i (mmio.wr_addr),
        .kind_o (wrKind),
        .idx_o  (wrIdx)
    );

    assign startWr = mmio.wr_en && (wrKind == RK_CTRL) && mmio.wr_data[CTRL_START_BIT];
    assign clearWr = mmio.wr_en && (wrKind == RK_CTRL) && mmio.wr_data[CTRL_CLEAR_BIT];
    assign segWr   = mmio.wr_en && ((wrKind == RK_SEG_ADDR) || (wrKind == RK_SEG_SIZE));

    // State register and all architectural registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cycles_q     <= '0;
            doneSticky_q <= 1'b0;
            errSticky_q  <= 1'b0;
            go_q         <= 1'b0;
            segAddr_q    <= '0;
            segSize_q    <= '0;
            rdData_q     <= '0;
        end else begin
            state_q      <= state_d;
            cycles_q     <= cycles_d;
            doneSticky_q <= doneSticky_d;
            errSticky_q  <= errSticky_d;
            go_q         <= go_d;
            segAddr_q    <= segAddr_d;
            segSize_q    <= segSize_d;
            rdData_q     <= rdData_d;
        end
    end

    // Next-state: clear first, then segment writes, then the run FSM; reads sample pre-write values
    always_comb begin
        state_d      = state_q;
        cycles_d     = cycles_q;
        doneSticky_d = doneSticky_q;
        errSticky_d  = errSticky_q;
        go_d         = 1'b0;
        segAddr_d    = segAddr_q;
        segSize_d    = segSize_q;
        rdData_d     = rdData_q;

        if (clearWr) begin
            doneSticky_d = 1'b0;
            errSticky_d  = 1'b0;
            cycles_d     = '0;
            if (state_q == COMPLETE) begin
                state_d = IDLE;
            end
        end

        if (segWr) begin
            if (state_q == RUN) begin
                errSticky_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_SEGS; i++) begin
                    if (wrIdx == SEG_IDX_W'(i)) begin
                        if (wrKind == RK_SEG_ADDR) begin
                            segAddr_d[i] = mmio.wr_data[ADDR_WIDTH-1:0];
                        end else begin
                            segSize_d[i] = mmio.wr_data[SIZE_WIDTH-1:0];
                        end
                    end
                end
            end
        end

        case (state_q)
            IDLE, COMPLETE: begin
                if (startWr) begin
                    state_d      = RUN;
                    go_d         = 1'b1;
                    cycles_d     = '0;
                    doneSticky_d = 1'b0;
                end
            end
            RUN: begin
                if (!clearWr && (cycles_q != '1)) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (startWr) begin
                    errSticky_d = 1'b1;
                end
                if (done) begin
                    state_d      = COMPLETE;
                    doneSticky_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (mmio.rd_en) begin
            rdData_d = '0;
            case (rdKind)
                RK_STATUS: rdData_d = pack_status(state_q == RUN, doneSticky_q,
                                                  errSticky_q, 8'(NUM_SEGS));
                RK_CYCLES: rdData_d = cycles_q;
                RK_CV:     rdData_d = MMIO_DATA_WIDTH'(cv_value);
                RK_SEG_ADDR: begin
                    for (int i = 0; i < NUM_SEGS; i++) begin
                        if (rdIdx == SEG_IDX_W'(i)) begin
                            rdData_d = MMIO_DATA_WIDTH'(segAddr_q[i]);
                        end
                    end
                end
                RK_SEG_SIZE: begin
                    for (int i = 0; i < NUM_SEGS; i++) begin
                        if (rdIdx == SEG_IDX_W'(i)) begin
                            rdData_d = MMIO_DATA_WIDTH'(segSize_q[i]);
                        end
                    end
                end
                default:   rdData_d = '0;
            endcase
        end
    end

    assign go           = go_q;
    assign busy         = (state_q == RUN);
    assign seg_addr     = segAddr_q;
    assign seg_size     = segSize_q;
    assign mmio.rd_data = rdData_q;

endmodule
